// File: rtl/trapez_peak_reader.sv
// Per-channel trapezoid peak reader: detects a pulse against a threshold and averages its flat-top.
// Each pulse becomes an amplitude/timestamp event in a small output FIFO with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a sample above threshold
// RISE  | skipping the ramp samples after the crossing
// FLAT  | accumulating the flat-top samples
// TAIL  | waiting for the pulse to fall back to threshold
module trapez_peak_reader #(
  parameter int FULL_SIZE    = 28,
  parameter int RISE_SAMPLES = 2,
  parameter int FLAT_SHIFT   = 1,
  parameter int MAX_TAIL     = 16,
  parameter int TS_SIZE      = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic signed [FULL_SIZE-1:0] in_data,
  input  logic signed [FULL_SIZE-1:0] threshold,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [FULL_SIZE-1:0] out_amplitude,
  output logic [TS_SIZE-1:0]          out_timestamp,
  output logic                        out_pileup,
  output logic [15:0]                 abort_cnt,
  output logic [15:0]                 drop_cnt
);

  localparam int FLAT_SAMPLES = 2 ** FLAT_SHIFT;
  localparam int ACC_W        = FULL_SIZE + FLAT_SHIFT;
  localparam int CNT_W        = 16;
  localparam int TAIL_W       = $clog2(MAX_TAIL + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PTR_W        = AW + 1;
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE_SAMPLES);
  localparam logic [CNT_W-1:0]  FLAT_LAST = CNT_W'(FLAT_SAMPLES);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(MAX_TAIL);

  typedef enum logic [1:0] {IDLE, RISE, FLAT, TAIL} state_t;

  state_t                      state;
  logic signed [FULL_SIZE-1:0] thr_l;
  logic [TS_SIZE-1:0]          ts_l;
  logic [TS_SIZE-1:0]          ts_cnt;
  logic [CNT_W-1:0]            cnt;
  logic [TAIL_W-1:0]           tail_cnt;
  logic signed [ACC_W-1:0]     acc;
  logic signed [FULL_SIZE-1:0] amp_l;
  logic                        pile_l;
  logic                        push_req;

  logic signed [ACC_W-1:0] din_ext, acc_sum, acc_avg;
  logic [CNT_W-1:0]        cnt_inc;
  logic [TAIL_W-1:0]       tail_inc;
  logic                    above;

  assign din_ext  = ACC_W'(in_data);
  assign acc_sum  = acc + din_ext;
  assign acc_avg  = acc_sum >>> FLAT_SHIFT;
  assign cnt_inc  = cnt + 1'b1;
  assign tail_inc = tail_cnt + 1'b1;
  assign above    = in_data > thr_l;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      thr_l     <= '0;
      ts_l      <= '0;
      cnt       <= '0;
      tail_cnt  <= '0;
      acc       <= '0;
      amp_l     <= '0;
      pile_l    <= 1'b0;
      push_req  <= 1'b0;
      abort_cnt <= '0;
    end else begin
      push_req <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: if (in_data > threshold) begin
            thr_l    <= threshold;
            ts_l     <= ts_cnt;
            pile_l   <= 1'b0;
            tail_cnt <= '0;
            acc      <= '0;
            if (RISE_LAST == CNT_W'(1)) begin
              cnt   <= '0;
              state <= FLAT;
            end else begin
              cnt   <= CNT_W'(1);
              state <= RISE;
            end
          end
          RISE: if (!above) begin
            if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 1'b1;
            state <= IDLE;
          end else if (cnt_inc == RISE_LAST) begin
            cnt   <= '0;
            acc   <= '0;
            state <= FLAT;
          end else begin
            cnt <= cnt_inc;
          end
          FLAT: if (!above) begin
            if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 1'b1;
            state <= IDLE;
          end else if (cnt_inc == FLAT_LAST) begin
            acc      <= acc_sum;
            amp_l    <= acc_avg[FULL_SIZE-1:0];
            cnt      <= '0;
            tail_cnt <= '0;
            state    <= TAIL;
          end else begin
            acc <= acc_sum;
            cnt <= cnt_inc;
          end
          TAIL: if (above) begin
            // tail counter saturates; pile-up flag stays set until the push
            if (tail_cnt != TAIL_LAST) tail_cnt <= tail_inc;
            if (tail_inc == TAIL_LAST) pile_l <= 1'b1;
          end else begin
            push_req <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic signed [FULL_SIZE-1:0] mem_amp  [FIFO_DEPTH];
  logic [TS_SIZE-1:0]          mem_ts   [FIFO_DEPTH];
  logic                        mem_pile [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        full, empty, pop, push, drop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop   = out_valid && out_ready;
  // a simultaneous pop frees the slot the push writes into
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  assign out_valid     = !empty;
  assign out_amplitude = mem_amp[rd_ptr[AW-1:0]];
  assign out_timestamp = mem_ts[rd_ptr[AW-1:0]];
  assign out_pileup    = mem_pile[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_amp[i]  <= '0;
        mem_ts[i]   <= '0;
        mem_pile[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_amp[wr_ptr[AW-1:0]]  <= amp_l;
        mem_ts[wr_ptr[AW-1:0]]   <= ts_l;
        mem_pile[wr_ptr[AW-1:0]] <= pile_l;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trapez_peak_reader.sv
// Directed bench for trapez_peak_reader: hand-computed events, aborts, pile-up, backpressure and reset.
module tb_trapez_peak_reader;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [27:0]  in_data = '0;
  logic signed [27:0]  threshold = 28'sd100;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [27:0]  out_amplitude;
  logic [31:0]         out_timestamp;
  logic                out_pileup;
  logic [15:0]         abort_cnt;
  logic [15:0]         drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc;
  int t;
  int tsa [6];

  trapez_peak_reader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_amplitude (out_amplitude),
    .out_timestamp (out_timestamp),
    .out_pileup    (out_pileup),
    .abort_cnt     (abort_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // clk count since reset release, the reference for expected timestamps
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input bit gap);
    in_valid = 1'b1;
    in_data  = 28'(d);
    step(1);
    in_valid = 1'b0;
    if (gap) step(1);
  endtask

  task automatic pulse(input int f0, input int f1, input bit gap, output int ts);
    send(0, gap);
    send(50, gap);
    ts = cyc;
    send(200, gap);
    send(400, gap);
    send(f0, gap);
    send(f1, gap);
    send(300, gap);
    send(50, gap);
  endtask

  task automatic head(input string tag, input int amp, input int ts, input int pile);
    chk({tag, "_valid"}, longint'(out_valid), 1);
    chk({tag, "_amp"}, longint'(out_amplitude), longint'(amp));
    chk({tag, "_ts"}, longint'(out_timestamp), longint'(ts));
    chk({tag, "_pile"}, longint'(out_pileup), longint'(pile));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, longint'(out_valid), 0);
    chk({tag, "_amp"}, longint'(out_amplitude), 0);
    chk({tag, "_ts"}, longint'(out_timestamp), 0);
    chk({tag, "_pile"}, longint'(out_pileup), 0);
    chk({tag, "_abort"}, longint'(abort_cnt), 0);
    chk({tag, "_drop"}, longint'(drop_cnt), 0);
  endtask

  initial begin
    step(2);
    chk_zero("rst");
    reset_n = 1'b1;
    step(1);

    // nominal pulse, including the two-clock latency to out_valid
    pulse(600, 602, 1'b0, t);
    chk("lat_early", longint'(out_valid), 0);
    step(1);
    head("nom", 601, t, 0);
    chk("nom_abort", longint'(abort_cnt), 0);
    pop();
    chk("nom_empty", longint'(out_valid), 0);

    // early abort in FLAT, then a clean pulse
    send(0, 1'b0);
    send(200, 1'b0);
    send(400, 1'b0);
    send(90, 1'b0);
    step(2);
    chk("abort_noev", longint'(out_valid), 0);
    chk("abort_cnt", longint'(abort_cnt), 1);
    pulse(700, 704, 1'b0, t);
    step(1);
    head("post_abort", 702, t, 0);
    pop();

    // pile-up
    send(0, 1'b0);
    t = cyc;
    send(200, 1'b0);
    send(400, 1'b0);
    send(600, 1'b0);
    send(600, 1'b0);
    repeat (20) send(500, 1'b0);
    send(0, 1'b0);
    step(1);
    head("pile", 600, t, 1);
    pop();

    // negative samples
    threshold = -28'sd50;
    send(-100, 1'b0);
    t = cyc;
    send(-30, 1'b0);
    send(-20, 1'b0);
    send(-10, 1'b0);
    send(-12, 1'b0);
    send(-60, 1'b0);
    step(1);
    head("neg", -11, t, 0);
    pop();
    threshold = 28'sd100;

    // in_valid gaps
    pulse(600, 602, 1'b1, t);
    step(1);
    head("gap", 601, t, 0);
    pop();
    chk("gap_abort", longint'(abort_cnt), 1);

    // backpressure: six pulses into a four-deep FIFO
    for (int i = 0; i < 6; i++) pulse(300 + 10 * i, 302 + 10 * i, 1'b0, tsa[i]);
    step(1);
    chk("bp_drop", longint'(drop_cnt), 2);
    head("bp_hold0", 301, tsa[0], 0);
    step(3);
    head("bp_hold1", 301, tsa[0], 0);
    for (int i = 0; i < 4; i++) begin
      head($sformatf("bp_q%0d", i), 301 + 10 * i, tsa[i], 0);
      pop();
    end
    chk("bp_empty", longint'(out_valid), 0);

    // push onto a full FIFO with a same-cycle pop
    for (int i = 0; i < 4; i++) pulse(400 + 10 * i, 402 + 10 * i, 1'b0, tsa[i]);
    step(1);
    pulse(440, 442, 1'b0, tsa[4]);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("sp_drop", longint'(drop_cnt), 2);
    for (int i = 1; i < 5; i++) begin
      head($sformatf("sp_q%0d", i), 401 + 10 * i, tsa[i], 0);
      pop();
    end
    chk("sp_empty", longint'(out_valid), 0);

    // reset mid-FLAT with an event already queued
    pulse(600, 602, 1'b0, t);
    step(1);
    send(0, 1'b0);
    send(200, 1'b0);
    send(400, 1'b0);
    send(600, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    step(1);
    reset_n = 1'b1;
    send(50, 1'b0);
    send(50, 1'b0);
    step(3);
    chk("rst_noev", longint'(out_valid), 0);
    chk("rst_abort", longint'(abort_cnt), 0);
    chk("rst_drop", longint'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
